// File: rtl/shift_sequencer_if.sv
// Request/strobe bundle between a requester and shift_sequencer.
// The master drives the request side; the slave (sequencer) drives the shift-register strobes and status.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic [CW-1:0]    shift_count;
  logic             serial_in;

  logic             sr_load;
  logic [WIDTH-1:0] sr_pdata;
  logic             sr_shift;
  logic             sr_msb_in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    shifts_left;

  modport master (
    output start, abort, data_in, shift_count, serial_in,
    input  sr_load, sr_pdata, sr_shift, sr_msb_in, busy, done, shifts_left
  );

  modport slave (
    input  start, abort, data_in, shift_count, serial_in,
    output sr_load, sr_pdata, sr_shift, sr_msb_in, busy, done, shifts_left
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences an external parallel-load / serial-shift register: one load, N paced right-shifts, done pulse.
// Outputs are Moore-decoded from state; sr_shift/sr_msb_in also depend on the prescaler and abort.
module shift_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CW       = 3,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              resetn,
  shift_sequencer_if.slave  bus
);
  localparam int unsigned PW = 8;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    prescaler;
  logic [PW-1:0]    prescaler_next;
  logic [CW-1:0]    shifts_left;
  logic [CW-1:0]    shifts_left_next;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] pdata_next;
  logic             tick;

  // State and sequencing registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      prescaler   <= '0;
      shifts_left <= '0;
      pdata       <= '0;
    end else begin
      state       <= state_next;
      prescaler   <= prescaler_next;
      shifts_left <= shifts_left_next;
      pdata       <= pdata_next;
    end
  end

  // Next-state and shift-tick decode; abort outranks a coincident shift tick
  always_comb begin
    state_next       = state;
    prescaler_next   = prescaler;
    shifts_left_next = shifts_left;
    pdata_next       = pdata;
    tick             = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          pdata_next       = bus.data_in;
          shifts_left_next = (bus.shift_count > MAX_COUNT) ? MAX_COUNT : bus.shift_count;
          state_next       = LOAD;
        end
      end

      LOAD: begin
        prescaler_next = '0;
        state_next     = (shifts_left == '0) ? DONE : SHIFT;
      end

      SHIFT: begin
        prescaler_next = (prescaler == LAST_TICK) ? '0 : prescaler + PW'(1);
        if (bus.abort) begin
          state_next = DONE;
        end else if (prescaler == LAST_TICK) begin
          tick             = 1'b1;
          shifts_left_next = shifts_left - CW'(1);
          if (shifts_left == CW'(1)) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.sr_load     = (state == LOAD);
  assign bus.sr_shift    = tick;
  assign bus.sr_msb_in   = tick & bus.serial_in;
  assign bus.sr_pdata    = pdata;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.shifts_left = shifts_left;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a TICK_DIV=4 instance and a TICK_DIV=1 instance,
// each driving a small model of the external shift register.
module tb_shift_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = 3;

  logic clk;
  logic resetn;
  int   passed;
  int   total;

  shift_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus4 ();
  shift_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus1 ();

  shift_sequencer #(.WIDTH(WIDTH), .CW(CW), .TICK_DIV(4)) dut4 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus4)
  );

  shift_sequencer #(.WIDTH(WIDTH), .CW(CW), .TICK_DIV(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift registers driven by the strobes
  logic [WIDTH-1:0] sr4;
  logic [WIDTH-1:0] sr1;
  always_ff @(posedge clk) begin
    if (bus4.sr_load)       sr4 <= bus4.sr_pdata;
    else if (bus4.sr_shift) sr4 <= {bus4.sr_msb_in, sr4[WIDTH-1:1]};
    if (bus1.sr_load)       sr1 <= bus1.sr_pdata;
    else if (bus1.sr_shift) sr1 <= {bus1.sr_msb_in, sr1[WIDTH-1:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Walks cycles 1..2+n*t of a sequence, checking every strobe against the latency rule
  task automatic sweep(input string name, input bit sel, input int n, input int t, input bit msb);
    int   last;
    logic ld, sh, ms, dn;
    bit   exp_sh;
    last = 2 + n * t;
    for (int c = 1; c <= last; c++) begin
      ld = sel ? bus1.sr_load   : bus4.sr_load;
      sh = sel ? bus1.sr_shift  : bus4.sr_shift;
      ms = sel ? bus1.sr_msb_in : bus4.sr_msb_in;
      dn = sel ? bus1.done      : bus4.done;
      exp_sh = (c > 1) && (c <= 1 + n * t) && (((c - 1) % t) == 0);
      check($sformatf("%s c%0d load", name, c),  32'(ld), 32'(c == 1));
      check($sformatf("%s c%0d shift", name, c), 32'(sh), 32'(exp_sh));
      check($sformatf("%s c%0d msb", name, c),   32'(ms), 32'(exp_sh & msb));
      check($sformatf("%s c%0d done", name, c),  32'(dn), 32'(c == last));
      step();
    end
  endtask

  task automatic start4(input logic [WIDTH-1:0] d, input logic [CW-1:0] cnt, input logic s);
    bus4.data_in     = d;
    bus4.shift_count = cnt;
    bus4.serial_in   = s;
    bus4.start       = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  initial begin
    int shifts_seen;
    passed = 0;
    total  = 0;
    resetn = 1'b0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.data_in = '0; bus4.shift_count = '0; bus4.serial_in = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.data_in = '0; bus1.shift_count = '0; bus1.serial_in = 1'b0;
    step();
    step();

    // Reset state
    check("rst busy",   32'(bus4.busy),        32'(0));
    check("rst done",   32'(bus4.done),        32'(0));
    check("rst load",   32'(bus4.sr_load),     32'(0));
    check("rst shift",  32'(bus4.sr_shift),    32'(0));
    check("rst left",   32'(bus4.shifts_left), 32'(0));
    check("rst pdata",  32'(bus4.sr_pdata),    32'(0));
    check("rst busy1",  32'(bus1.busy),        32'(0));
    resetn = 1'b1;
    step();

    // Basic sequence: 1011, 3 shifts filling with 1
    start4(4'b1011, 3'd3, 1'b1);
    check("basic pdata", 32'(bus4.sr_pdata),    32'(4'b1011));
    check("basic left",  32'(bus4.shifts_left), 32'(3));
    sweep("basic", 1'b0, 3, 4, 1'b1);
    check("basic idle busy", 32'(bus4.busy),        32'(0));
    check("basic idle left", 32'(bus4.shifts_left), 32'(0));
    check("basic sr",        32'(sr4),              32'(4'b1111));

    // Zero count: load then done
    start4(4'b0110, 3'd0, 1'b1);
    sweep("zero", 1'b0, 0, 4, 1'b1);
    check("zero busy", 32'(bus4.busy), 32'(0));
    check("zero sr",   32'(sr4),       32'(4'b0110));

    // Count 7 clamps to WIDTH
    start4(4'b1010, 3'd7, 1'b0);
    check("clamp left", 32'(bus4.shifts_left), 32'(4));
    sweep("clamp", 1'b0, 4, 4, 1'b0);
    check("clamp idle left", 32'(bus4.shifts_left), 32'(0));
    check("clamp sr",        32'(sr4),              32'(4'b0000));

    // Abort on the cycle of the second shift tick (cycle 9)
    start4(4'b1100, 3'd4, 1'b1);
    shifts_seen = 0;
    for (int c = 1; c <= 8; c++) begin
      shifts_seen += 32'(bus4.sr_shift);
      step();
    end
    bus4.abort = 1'b1;
    #1;
    check("abort shift blocked", 32'(bus4.sr_shift),    32'(0));
    check("abort left c9",       32'(bus4.shifts_left), 32'(3));
    step();
    bus4.abort = 1'b0;
    check("abort done",      32'(bus4.done),        32'(1));
    check("abort left done", 32'(bus4.shifts_left), 32'(3));
    check("abort shifts",    32'(shifts_seen),      32'(1));
    step();
    check("abort idle busy", 32'(bus4.busy),        32'(0));
    check("abort idle left", 32'(bus4.shifts_left), 32'(3));
    check("abort sr",        32'(sr4),              32'(4'b1110));

    // Start while busy: mid-SHIFT pulse ignored, held start restarts after DONE
    start4(4'b0101, 3'd1, 1'b0);
    step();
    step();
    bus4.data_in = 4'b1111;
    bus4.start   = 1'b1;
    step();
    bus4.start = 1'b0;
    check("busy pdata kept", 32'(bus4.sr_pdata), 32'(4'b0101));
    check("busy no load",    32'(bus4.sr_load),  32'(0));
    step();
    check("busy shift c5", 32'(bus4.sr_shift), 32'(1));
    bus4.data_in     = 4'b0011;
    bus4.shift_count = 3'd0;
    bus4.start       = 1'b1;
    step();
    check("busy done c6",    32'(bus4.done),    32'(1));
    check("busy no load c6", 32'(bus4.sr_load), 32'(0));
    step();
    check("busy idle c7",    32'(bus4.busy),    32'(0));
    check("busy no load c7", 32'(bus4.sr_load), 32'(0));
    step();
    bus4.start = 1'b0;
    check("restart load",  32'(bus4.sr_load),  32'(1));
    check("restart pdata", 32'(bus4.sr_pdata), 32'(4'b0011));
    step();
    check("restart done", 32'(bus4.done), 32'(1));
    step();

    // TICK_DIV=1 instance: 4 back-to-back shifts
    bus1.data_in     = 4'b0000;
    bus1.shift_count = 3'd4;
    bus1.serial_in   = 1'b1;
    bus1.start       = 1'b1;
    step();
    bus1.start = 1'b0;
    sweep("t1", 1'b1, 4, 1, 1'b1);
    check("t1 busy", 32'(bus1.busy), 32'(0));
    check("t1 sr",   32'(sr1),       32'(4'b1111));

    // Reset asserted mid-SHIFT, between edges
    start4(4'b1001, 3'd4, 1'b1);
    step();
    check("mid shift busy", 32'(bus4.busy), 32'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("arst busy",  32'(bus4.busy),        32'(0));
    check("arst load",  32'(bus4.sr_load),     32'(0));
    check("arst shift", 32'(bus4.sr_shift),    32'(0));
    check("arst msb",   32'(bus4.sr_msb_in),   32'(0));
    check("arst done",  32'(bus4.done),        32'(0));
    check("arst left",  32'(bus4.shifts_left), 32'(0));
    check("arst pdata", 32'(bus4.sr_pdata),    32'(0));
    step();
    resetn = 1'b1;
    shifts_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      shifts_seen += 32'(bus4.sr_shift) + 32'(bus4.sr_load) + 32'(bus4.done);
    end
    check("post rst strobes", 32'(shifts_seen), 32'(0));
    check("post rst busy",    32'(bus4.busy),   32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
